// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite to MMIO bridge: response codes and the bridge FSM states.
// Pure type definitions; no logic, no latency, no flow control.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WRESP,
        RD,
        RWAIT,
        RRESP
    } state_e;

endpackage

// File: rtl/axil2mmio.sv
// AXI4-Lite slave to one-cycle MMIO strobes, one transaction in flight, round-robin write/read grant.
// Latency: mmio_wr_en 1 cycle after accept, bvalid 2; mmio_rd_en 1 cycle after accept, rvalid RD_LATENCY+2.
// Backpressure: B/R responses held until ready; no new request accepted until the response completes. Optional: AXIL2MMIO_ALIGN_CHECK_EN.
module axil2mmio
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,

    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,

    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,

    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,

    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,

    output logic                    mmio_wr_en,
    output logic [ADDR_WIDTH-1:0]   mmio_wr_addr,
    output logic [DATA_WIDTH-1:0]   mmio_wr_data,
    output logic [DATA_WIDTH/8-1:0] mmio_wr_byteen,

    output logic                    mmio_rd_en,
    output logic [ADDR_WIDTH-1:0]   mmio_rd_addr,
    input  logic [DATA_WIDTH-1:0]   mmio_rd_data
);

    localparam int CNT_W = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LATENCY - 1);

    state_e           state;
    state_e           state_nxt;
    logic             last_wr;
    logic             err_q;
    logic [CNT_W-1:0] cnt;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic wr_req;
    logic rd_req;
    logic wr_gnt;
    logic rd_gnt;
    logic wr_acc;
    logic rd_acc;
    logic aw_misaligned;
    logic ar_misaligned;

`ifdef AXIL2MMIO_ALIGN_CHECK_EN
    localparam int ALIGN_BITS = $clog2(DATA_WIDTH / 8);
    assign aw_misaligned = |s_awaddr[ALIGN_BITS-1:0];
    assign ar_misaligned = |s_araddr[ALIGN_BITS-1:0];
`else
    assign aw_misaligned = 1'b0;
    assign ar_misaligned = 1'b0;
`endif

    // A write only competes once both AW and W are present; last_wr favours the other class on a tie.
    assign wr_req = s_awvalid && s_wvalid;
    assign rd_req = s_arvalid;
    assign wr_gnt = wr_req && (!rd_req || !last_wr);
    assign rd_gnt = rd_req && (!wr_req || last_wr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_wr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (wr_acc) begin
                last_wr <= 1'b1;
            end else if (rd_acc) begin
                last_wr <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        s_awready  = 1'b0;
        s_wready   = 1'b0;
        s_arready  = 1'b0;
        s_bvalid   = 1'b0;
        s_rvalid   = 1'b0;
        mmio_wr_en = 1'b0;
        mmio_rd_en = 1'b0;
        wr_acc     = 1'b0;
        rd_acc     = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (wr_gnt) begin
                        wr_acc    = 1'b1;
                        s_awready = 1'b1;
                        s_wready  = 1'b1;
                        state_nxt = WR;
                    end else if (rd_gnt) begin
                        rd_acc    = 1'b1;
                        s_arready = 1'b1;
                        state_nxt = RD;
                    end
                end
            end
            WR: begin
                mmio_wr_en = !err_q;
                state_nxt  = WRESP;
            end
            WRESP: begin
                s_bvalid = 1'b1;
                if (s_bready) begin
                    state_nxt = IDLE;
                end
            end
            RD: begin
                mmio_rd_en = !err_q;
                state_nxt  = RWAIT;
            end
            RWAIT: begin
                if (cnt == '0) begin
                    state_nxt = RRESP;
                end
            end
            RRESP: begin
                s_rvalid = 1'b1;
                if (s_rready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured at accept so the strobe cycle presents registered values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mmio_wr_addr   <= '0;
            mmio_wr_data   <= '0;
            mmio_wr_byteen <= '0;
            mmio_rd_addr   <= '0;
            err_q          <= 1'b0;
            cnt            <= '0;
            rdata_q        <= '0;
        end else begin
            if (wr_acc) begin
                mmio_wr_addr   <= s_awaddr;
                mmio_wr_data   <= s_wdata;
                mmio_wr_byteen <= s_wstrb;
                err_q          <= aw_misaligned;
            end
            if (rd_acc) begin
                mmio_rd_addr <= s_araddr;
                err_q        <= ar_misaligned;
            end
            if (state == RD) begin
                cnt <= CNT_INIT;
            end else if (state == RWAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == RWAIT && cnt == '0) begin
                rdata_q <= err_q ? '0 : mmio_rd_data;
            end
        end
    end

    assign s_rdata = rdata_q;
    assign s_bresp = (state == WRESP && err_q) ? SLVERR : OKAY;
    assign s_rresp = (state == RRESP && err_q) ? SLVERR : OKAY;

endmodule

// File: tb/tb_axil2mmio.sv
// Bench for axil2mmio: scoreboard of expected MMIO strobes and B/R responses, plus latency and reset checks.
module tb_axil2mmio;

    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int SW  = DW / 8;
    localparam int RDL = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] s_awaddr;
    logic          s_awvalid;
    logic          s_awready;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;
    logic          s_wvalid;
    logic          s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready;
    logic [AW-1:0] s_araddr;
    logic          s_arvalid;
    logic          s_arready;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready;
    logic          mmio_wr_en;
    logic [AW-1:0] mmio_wr_addr;
    logic [DW-1:0] mmio_wr_data;
    logic [SW-1:0] mmio_wr_byteen;
    logic          mmio_rd_en;
    logic [AW-1:0] mmio_rd_addr;
    logic [DW-1:0] mmio_rd_data;

    always #5 clk = ~clk;

    axil2mmio #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RDL)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .mmio_wr_en(mmio_wr_en), .mmio_wr_addr(mmio_wr_addr), .mmio_wr_data(mmio_wr_data),
        .mmio_wr_byteen(mmio_wr_byteen),
        .mmio_rd_en(mmio_rd_en), .mmio_rd_addr(mmio_rd_addr), .mmio_rd_data(mmio_rd_data)
    );

    typedef struct packed {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } mmio_exp_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rsp_t;

    mmio_exp_t  exp_mmio[$];
    logic [1:0] exp_b[$];
    rsp_t       exp_r[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int aw_acc_cyc, ar_acc_cyc, wr_en_cyc, rd_en_cyc, b_first_cyc, r_first_cyc;
    int aw_acc_cnt = 0, wr_en_cnt = 0, rd_en_cnt = 0, rvalid_cnt = 0;
    int overlap_cnt = 0, pair_err_cnt = 0;
    int snap, snap2;
    logic bvalid_d = 1'b0;
    logic rvalid_d = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // MMIO slave read data: address-dependent pattern, valid only RDL cycles after a strobe, zero otherwise.
    function automatic logic [63:0] rd_model(input logic [31:0] a);
        if (a == 32'h200) return 64'hDEAD_BEEF;
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    logic [DW-1:0] rd_pipe [RDL];
    always @(posedge clk) begin
        rd_pipe[0] <= mmio_rd_en ? rd_model(mmio_rd_addr) : '0;
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mmio_rd_data = rd_pipe[RDL-1];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        mmio_exp_t e;
        rsp_t      r;
        if (mmio_wr_en && mmio_rd_en) overlap_cnt++;
        if (s_awready != s_wready) pair_err_cnt++;
        if (s_awready && s_awvalid) begin aw_acc_cyc = cyc; aw_acc_cnt++; end
        if (s_arready && s_arvalid) ar_acc_cyc = cyc;
        if (s_rvalid) rvalid_cnt++;
        if (s_bvalid && !bvalid_d) b_first_cyc = cyc;
        if (s_rvalid && !rvalid_d) r_first_cyc = cyc;
        bvalid_d = s_bvalid;
        rvalid_d = s_rvalid;
        if (mmio_wr_en) begin
            wr_en_cyc = cyc;
            wr_en_cnt++;
            if (exp_mmio.size() == 0) chk("wr_en_unexpected", 64'(1), 64'(0));
            else begin
                e = exp_mmio.pop_front();
                chk("order_is_wr", 64'(1), 64'(e.is_wr));
                chk("wr_addr", 64'(mmio_wr_addr), 64'(e.addr));
                chk("wr_data", mmio_wr_data, e.data);
                chk("wr_byteen", 64'(mmio_wr_byteen), 64'(e.strb));
            end
        end
        if (mmio_rd_en) begin
            rd_en_cyc = cyc;
            rd_en_cnt++;
            if (exp_mmio.size() == 0) chk("rd_en_unexpected", 64'(1), 64'(0));
            else begin
                e = exp_mmio.pop_front();
                chk("order_is_rd", 64'(1), 64'(!e.is_wr));
                chk("rd_addr", 64'(mmio_rd_addr), 64'(e.addr));
            end
        end
        if (s_bvalid && s_bready) begin
            if (exp_b.size() == 0) chk("b_unexpected", 64'(1), 64'(0));
            else chk("bresp", 64'(s_bresp), 64'(exp_b.pop_front()));
        end
        if (s_rvalid && s_rready) begin
            if (exp_r.size() == 0) chk("r_unexpected", 64'(1), 64'(0));
            else begin
                r = exp_r.pop_front();
                chk("rdata", s_rdata, r.data);
                chk("rresp", 64'(s_rresp), 64'(r.resp));
            end
        end
    end

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        exp_mmio.push_back('{is_wr: 1'b1, addr: a, data: d, strb: s});
        exp_b.push_back(2'b00);
    endtask

    task automatic push_rd(input logic [AW-1:0] a);
        exp_mmio.push_back('{is_wr: 1'b0, addr: a, data: '0, strb: '0});
        exp_r.push_back('{data: rd_model(a), resp: 2'b00});
    endtask

    task automatic wait_aw();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_awready && s_wready) return;
        end
        chk("aw_accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_ar();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_arready) return;
        end
        chk("ar_accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_b();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_bvalid && s_bready) return;
        end
        chk("b_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_r();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_rvalid && s_rready) return;
        end
        chk("r_timeout", 64'(0), 64'(1));
    endtask

    // Called just after a rising edge; returns just after the edge following the response handshake.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        wait_aw();
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        wait_b();
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        s_araddr = a;
        s_arvalid = 1'b1;
        wait_ar();
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        wait_r();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        s_awaddr = 32'h40; s_awvalid = 1'b1;
        s_wdata = 64'h1; s_wstrb = '1; s_wvalid = 1'b1;
        s_araddr = 32'h80; s_arvalid = 1'b1;
        s_bready = 1'b1; s_rready = 1'b1;

        // Reset state, with every request valid held high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'({s_awready, s_wready, s_arready}), 64'(0));
        chk("rst_valid_en", 64'({s_bvalid, s_rvalid, mmio_wr_en, mmio_rd_en}), 64'(0));
        chk("rst_resp", 64'({s_bresp, s_rresp}), 64'(0));
        chk("rst_rdata", s_rdata, 64'(0));
        chk("rst_mmio_fields", 64'({mmio_wr_addr, mmio_rd_addr}), 64'(0));
        chk("rst_mmio_data", mmio_wr_data ^ 64'(mmio_wr_byteen), 64'(0));
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        rst = 1'b0;

        // Basic write with latency check.
        push_wr(32'h100, 64'h1122_3344_5566_7788, 8'hFF);
        do_write(32'h100, 64'h1122_3344_5566_7788, 8'hFF);
        chk("wr_en_latency", 64'(wr_en_cyc - aw_acc_cyc), 64'(1));
        chk("bvalid_latency", 64'(b_first_cyc - aw_acc_cyc), 64'(2));

        // Basic read with latency check.
        push_rd(32'h200);
        do_read(32'h200);
        chk("rd_en_latency", 64'(rd_en_cyc - ar_acc_cyc), 64'(1));
        chk("rvalid_latency", 64'(r_first_cyc - ar_acc_cyc), 64'(RDL + 2));

        // Round-robin from reset: W,R then W,R; after a lone write, a tie goes to the read.
        do_reset();
        push_wr(32'h10, 64'hA1, 8'hFF); push_rd(32'h20);
        fork do_write(32'h10, 64'hA1, 8'hFF); do_read(32'h20); join
        push_wr(32'h18, 64'hB2, 8'h0F); push_rd(32'h28);
        fork do_write(32'h18, 64'hB2, 8'h0F); do_read(32'h28); join
        push_wr(32'h30, 64'hC3, 8'hF0);
        do_write(32'h30, 64'hC3, 8'hF0);
        push_rd(32'h38); push_wr(32'h40, 64'hD4, 8'h3C);
        fork do_write(32'h40, 64'hD4, 8'h3C); do_read(32'h38); join

        // AW without W is never accepted; a read goes ahead of it.
        snap = aw_acc_cnt;
        s_awaddr = 32'h500; s_awvalid = 1'b1;
        push_rd(32'h208);
        do_read(32'h208);
        chk("aw_alone_not_accepted", 64'(aw_acc_cnt - snap), 64'(0));
        push_wr(32'h500, 64'h0123_4567_89AB_CDEF, 8'h5A);
        do_write(32'h500, 64'h0123_4567_89AB_CDEF, 8'h5A);

        // rready held low: response stable, no new read accepted meanwhile.
        push_rd(32'h300); push_rd(32'h308);
        s_rready = 1'b0;
        s_araddr = 32'h300; s_arvalid = 1'b1;
        wait_ar();
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_rvalid) break;
            if (i == 99) chk("rvalid_timeout", 64'(0), 64'(1));
        end
        @(posedge clk); #1;
        s_araddr = 32'h308; s_arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rvalid", 64'(s_rvalid), 64'(1));
            chk("hold_rdata", s_rdata, rd_model(32'h300));
            chk("hold_no_arready", 64'(s_arready), 64'(0));
        end
        @(posedge clk); #1;
        s_rready = 1'b1;
        wait_ar();
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        wait_r();
        @(posedge clk); #1;

        // Reset during RWAIT aborts the read.
        exp_mmio.push_back('{is_wr: 1'b0, addr: 32'h400, data: '0, strb: '0});
        s_araddr = 32'h400; s_arvalid = 1'b1;
        wait_ar();
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_ctl", 64'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, mmio_wr_en, mmio_rd_en}), 64'(0));
        chk("rst_mid_rdata", s_rdata, 64'(0));
        chk("rst_mid_rd_addr", 64'(mmio_rd_addr), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        snap = rvalid_cnt;
        snap2 = rd_en_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_no_rvalid_after", 64'(rvalid_cnt - snap), 64'(0));
        chk("rst_no_rd_en_after", 64'(rd_en_cnt - snap2), 64'(0));

`ifdef AXIL2MMIO_ALIGN_CHECK_EN
        // Misaligned accesses: no strobe, SLVERR, zero read data.
        exp_b.push_back(2'b10);
        snap = wr_en_cnt;
        do_write(32'h104, 64'hFFFF_0000_FFFF_0000, 8'hFF);
        chk("misalign_no_wr_en", 64'(wr_en_cnt - snap), 64'(0));
        exp_r.push_back('{data: '0, resp: 2'b10});
        snap = rd_en_cnt;
        do_read(32'h10C);
        chk("misalign_no_rd_en", 64'(rd_en_cnt - snap), 64'(0));
`endif

        // Aligned traffic still works after all of the above.
        push_wr(32'h600, 64'h5555_AAAA_5555_AAAA, 8'h81);
        do_write(32'h600, 64'h5555_AAAA_5555_AAAA, 8'h81);
        push_rd(32'h608);
        do_read(32'h608);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_mmio_empty", 64'(exp_mmio.size()), 64'(0));
        chk("sb_b_empty", 64'(exp_b.size()), 64'(0));
        chk("sb_r_empty", 64'(exp_r.size()), 64'(0));
        chk("strobe_overlap", 64'(overlap_cnt), 64'(0));
        chk("aw_w_ready_pair", 64'(pair_err_cnt), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
